// File: rtl/coherence_pkg.sv
// Shared encodings for the snoop controller: line states, bus messages,
// controller FSM states and the role selector for the transition function.
package coherence_pkg;

  typedef enum logic [1:0] {
    LINE_INVALID  = 2'b00,
    LINE_MODIFIED = 2'b01,
    LINE_SHARED   = 2'b10
  } lineState_t;

  typedef enum logic [1:0] {
    MSG_INVALIDATE = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    MSG_NONE       = 2'b11
  } busMsg_t;

  typedef enum logic {
    FSM_IDLE    = 1'b0,
    FSM_WB_WAIT = 1'b1
  } fsmState_t;

  typedef enum logic {
    ROLE_SNOOP = 1'b0,
    ROLE_CPU   = 1'b1
  } role_t;

endpackage

// File: rtl/coherence_transition.sv
// Per-line coherence transition. For the CPU role the op is encoded as
// MSG_WRITE_MISS for a write and anything else for a read; the bus message to
// emit (if any) is returned on outMsg.
module coherence_transition
  import coherence_pkg::*;
(
  input  role_t      role,
  input  lineState_t curState,
  input  logic       tagMatch,
  input  busMsg_t    op,
  output lineState_t nextState,
  output logic       writeBack,
  output logic       abort,
  output logic       loadTag,
  output logic       sendMsg,
  output busMsg_t    outMsg
);

  logic hit;
  assign hit = (curState != LINE_INVALID) && tagMatch;

  // Next line state and side effects for one snoop or one local access
  always_comb begin
    nextState = curState;
    writeBack = 1'b0;
    abort     = 1'b0;
    loadTag   = 1'b0;
    sendMsg   = 1'b0;
    outMsg    = MSG_NONE;
    if (role == ROLE_SNOOP) begin
      if (hit) begin
        case (curState)
          LINE_MODIFIED: begin
            // Dirty data must go back to memory; memory's own reply is stale.
            if (op == MSG_READ_MISS) begin
              nextState = LINE_SHARED;
              writeBack = 1'b1;
              abort     = 1'b1;
            end else if (op == MSG_WRITE_MISS) begin
              nextState = LINE_INVALID;
              writeBack = 1'b1;
              abort     = 1'b1;
            end
          end
          LINE_SHARED: begin
            if (op == MSG_INVALIDATE || op == MSG_WRITE_MISS) begin
              nextState = LINE_INVALID;
            end
          end
          default: ;
        endcase
      end
    end else begin
      if (hit) begin
        if (op == MSG_WRITE_MISS && curState == LINE_SHARED) begin
          nextState = LINE_MODIFIED;
          sendMsg   = 1'b1;
          outMsg    = MSG_INVALIDATE;
        end
      end else begin
        loadTag   = 1'b1;
        sendMsg   = 1'b1;
        // Evicting a dirty line writes back its old tag; no memory abort.
        writeBack = (curState == LINE_MODIFIED);
        if (op == MSG_WRITE_MISS) begin
          nextState = LINE_MODIFIED;
          outMsg    = MSG_WRITE_MISS;
        end else begin
          nextState = LINE_SHARED;
          outMsg    = MSG_READ_MISS;
        end
      end
    end
  end

endmodule

// File: rtl/coherence_snoop_ctrl.sv
// Snooping MSI controller for a small direct-mapped line array. At most one
// operation (snoop or local access) updates one line per cycle; snoops win.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   FSM_IDLE    | accepting snoops and local accesses
//   FSM_WB_WAIT | write-back pending, wb_req held until wb_ack
module coherence_snoop_ctrl
  import coherence_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_msg,
  input  logic [IDX_W-1:0] snoop_idx,
  input  logic [TAG_W-1:0] snoop_tag,
  output logic             snoop_ready,
  input  logic             cpu_valid,
  input  logic             cpu_write,
  input  logic [IDX_W-1:0] cpu_idx,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ready,
  output logic             bus_msg_valid,
  output logic [1:0]       bus_msg,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  output logic [TAG_W-1:0] wb_tag,
  input  logic             wb_ack,
  output logic             abort_mem,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [1:0]       dbg_state
);

  localparam int NUM_LINES = 2**IDX_W;

  lineState_t       lineState [NUM_LINES];
  logic [TAG_W-1:0] lineTag   [NUM_LINES];

  fsmState_t fsmState, fsmNext;

  logic             snoopActive, cpuAccept, opActive;
  role_t            opRole;
  logic [IDX_W-1:0] opIdx;
  logic [TAG_W-1:0] opTag;
  busMsg_t          opMsg;

  lineState_t trNext;
  logic       trWriteBack, trAbort, trLoadTag, trSendMsg;
  busMsg_t    trOutMsg;

  logic             busMsgValidQ;
  busMsg_t          busMsgQ;
  logic             abortQ;
  logic [IDX_W-1:0] wbIdxQ;
  logic [TAG_W-1:0] wbTagQ;

  // A msg-11 snoop is accepted but inert, so it does not block the CPU.
  assign snoopActive = snoop_valid && snoop_ready && (snoop_msg != MSG_NONE);
  assign cpuAccept   = cpu_valid && cpu_ready;
  assign opActive    = snoopActive || cpuAccept;

  // Select the single operation that owns the transition function this cycle
  always_comb begin
    if (snoopActive) begin
      opRole = ROLE_SNOOP;
      opIdx  = snoop_idx;
      opTag  = snoop_tag;
      opMsg  = busMsg_t'(snoop_msg);
    end else begin
      opRole = ROLE_CPU;
      opIdx  = cpu_idx;
      opTag  = cpu_tag;
      opMsg  = cpu_write ? MSG_WRITE_MISS : MSG_READ_MISS;
    end
  end

  coherence_transition uTransition (
    .role      (opRole),
    .curState  (lineState[opIdx]),
    .tagMatch  (lineTag[opIdx] == opTag),
    .op        (opMsg),
    .nextState (trNext),
    .writeBack (trWriteBack),
    .abort     (trAbort),
    .loadTag   (trLoadTag),
    .sendMsg   (trSendMsg),
    .outMsg    (trOutMsg)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) fsmState <= FSM_IDLE;
    else       fsmState <= fsmNext;
  end

  // FSM next state: park in WB_WAIT for any write-back until acknowledged
  always_comb begin
    fsmNext = fsmState;
    case (fsmState)
      FSM_IDLE:    if (opActive && trWriteBack) fsmNext = FSM_WB_WAIT;
      FSM_WB_WAIT: if (wb_ack) fsmNext = FSM_IDLE;
      default:     fsmNext = FSM_IDLE;
    endcase
  end

  // FSM outputs: handshake readiness and write-back request
  always_comb begin
    snoop_ready = (fsmState == FSM_IDLE);
    cpu_ready   = (fsmState == FSM_IDLE) && !(snoop_valid && (snoop_msg != MSG_NONE));
    wb_req      = (fsmState == FSM_WB_WAIT);
  end

  // Line array: one line updated on the accepting edge
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lineState[i] <= LINE_INVALID;
        lineTag[i]   <= '0;
      end
    end else if (opActive) begin
      lineState[opIdx] <= trNext;
      if (trLoadTag) lineTag[opIdx] <= opTag;
    end
  end

  // Registered bus message, abort pulse and write-back address
  always_ff @(posedge clock) begin
    if (reset) begin
      busMsgValidQ <= 1'b0;
      busMsgQ      <= MSG_NONE;
      abortQ       <= 1'b0;
      wbIdxQ       <= '0;
      wbTagQ       <= '0;
    end else begin
      busMsgValidQ <= opActive && trSendMsg;
      busMsgQ      <= (opActive && trSendMsg) ? trOutMsg : MSG_NONE;
      abortQ       <= opActive && trAbort;
      if (opActive && trWriteBack) begin
        wbIdxQ <= opIdx;
        wbTagQ <= lineTag[opIdx];
      end
    end
  end

  assign bus_msg_valid = busMsgValidQ;
  assign bus_msg       = busMsgQ;
  assign abort_mem     = abortQ;
  assign wb_idx        = wbIdxQ;
  assign wb_tag        = wbTagQ;
  assign dbg_state     = lineState[dbg_idx];

endmodule

// File: tb/tb_coherence_snoop_ctrl.sv
// Directed bench for coherence_snoop_ctrl: stimulus pushes expected bus
// messages / write-backs into a queue, a negedge monitor pops and compares.
module tb_coherence_snoop_ctrl;

  localparam int IDX_W = 2;
  localparam int TAG_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             snoop_valid;
  logic [1:0]       snoop_msg;
  logic [IDX_W-1:0] snoop_idx;
  logic [TAG_W-1:0] snoop_tag;
  logic             snoop_ready;
  logic             cpu_valid;
  logic             cpu_write;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             cpu_ready;
  logic             bus_msg_valid;
  logic [1:0]       bus_msg;
  logic             wb_req;
  logic [IDX_W-1:0] wb_idx;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_ack;
  logic             abort_mem;
  logic [IDX_W-1:0] dbg_idx;
  logic [1:0]       dbg_state;

  always #5 clock = ~clock;

  coherence_snoop_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .snoop_valid(snoop_valid), .snoop_msg(snoop_msg), .snoop_idx(snoop_idx),
    .snoop_tag(snoop_tag), .snoop_ready(snoop_ready),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_idx(cpu_idx),
    .cpu_tag(cpu_tag), .cpu_ready(cpu_ready),
    .bus_msg_valid(bus_msg_valid), .bus_msg(bus_msg),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_tag(wb_tag), .wb_ack(wb_ack),
    .abort_mem(abort_mem), .dbg_idx(dbg_idx), .dbg_state(dbg_state)
  );

  typedef struct {
    bit         isWb;
    logic [1:0] msg;
    logic [1:0] idx;
    logic [7:0] tag;
    logic       abrt;
  } exp_t;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  logic prevWbReq   = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic void pushBus(input logic [1:0] m);
    exp_t e;
    e.isWb = 1'b0; e.msg = m; e.idx = '0; e.tag = '0; e.abrt = 1'b0;
    expQ.push_back(e);
  endfunction

  function automatic void pushWb(input logic [1:0] i, input logic [7:0] t, input logic a);
    exp_t e;
    e.isWb = 1'b1; e.msg = 2'b11; e.idx = i; e.tag = t; e.abrt = a;
    expQ.push_back(e);
  endfunction

  // Monitor: every bus message and every write-back start must match the queue head
  always @(negedge clock) begin
    exp_t e;
    if (bus_msg_valid === 1'b1) begin
      nCompared++;
      if (expQ.size() == 0 || expQ[0].isWb) begin
        nMismatched++;
        $display("FAIL unexpected_bus_msg: got msg %0h, nothing expected", bus_msg);
      end else begin
        e = expQ.pop_front();
        if (bus_msg !== e.msg) begin
          nMismatched++;
          $display("FAIL bus_msg: got %0h expected %0h", bus_msg, e.msg);
        end
      end
    end else if (bus_msg !== 2'b11) begin
      nCompared++;
      nMismatched++;
      $display("FAIL bus_msg_idle: got %0h expected 3", bus_msg);
    end
    if (wb_req === 1'b1 && prevWbReq !== 1'b1) begin
      nCompared++;
      if (expQ.size() == 0 || !expQ[0].isWb) begin
        nMismatched++;
        $display("FAIL unexpected_wb: got idx %0h tag %0h, nothing expected", wb_idx, wb_tag);
      end else begin
        e = expQ.pop_front();
        if (wb_idx !== e.idx || wb_tag !== e.tag || abort_mem !== e.abrt) begin
          nMismatched++;
          $display("FAIL wb_start: got idx %0h tag %0h abort %0b expected idx %0h tag %0h abort %0b",
                   wb_idx, wb_tag, abort_mem, e.idx, e.tag, e.abrt);
        end
      end
    end else if (abort_mem !== 1'b0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL abort_stray: got %0b expected 0", abort_mem);
    end
    prevWbReq = wb_req;
  end

  task automatic cpuReq(input logic wr, input logic [1:0] idx, input logic [7:0] tag);
    int n = 0;
    @(negedge clock);
    cpu_valid = 1'b1; cpu_write = wr; cpu_idx = idx; cpu_tag = tag;
    #1;
    while (cpu_ready !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (cpu_ready !== 1'b1) begin
      nCompared++; nMismatched++;
      $display("FAIL cpu_ready_timeout: got %0b expected 1", cpu_ready);
    end
    @(posedge clock); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic snoopReq(input logic [1:0] m, input logic [1:0] idx, input logic [7:0] tag);
    @(negedge clock);
    snoop_valid = 1'b1; snoop_msg = m; snoop_idx = idx; snoop_tag = tag;
    #1;
    check("snoop_ready_at_issue", snoop_ready, 1);
    @(posedge clock); #1;
    snoop_valid = 1'b0; snoop_msg = 2'b11;
  endtask

  task automatic checkDbg(input string name, input logic [1:0] idx, input logic [1:0] exp);
    @(negedge clock);
    dbg_idx = idx;
    #1;
    check(name, dbg_state, exp);
  endtask

  task automatic ackWb();
    int n = 0;
    while (wb_req !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (wb_req !== 1'b1) begin
      nCompared++; nMismatched++;
      $display("FAIL wb_req_timeout: got %0b expected 1", wb_req);
    end
    @(negedge clock);
    wb_ack = 1'b1;
    @(posedge clock); #1;
    wb_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; snoop_valid = 1'b0; snoop_msg = 2'b11; snoop_idx = '0; snoop_tag = '0;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_idx = '0; cpu_tag = '0;
    wb_ack = 1'b0; dbg_idx = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_bus_msg", bus_msg, 2'b11);
    check("rst_bus_msg_valid", bus_msg_valid, 0);
    check("rst_wb_req", wb_req, 0);
    check("rst_abort", abort_mem, 0);
    check("rst_wb_addr", {wb_idx, wb_tag}, 0);
    check("rst_snoop_ready", snoop_ready, 1);
    for (int i = 0; i < 4; i++) checkDbg("rst_line_state", i[1:0], 2'b00);

    // CPU write miss: line 1 becomes modified, bus write-miss message
    pushBus(2'b10);
    cpuReq(1'b1, 2'd1, 8'h5A);
    checkDbg("wmiss_state", 2'd1, 2'b01);

    // Snoop read miss on modified line: shared, write-back with abort
    pushWb(2'd1, 8'h5A, 1'b1);
    snoopReq(2'b01, 2'd1, 8'h5A);
    @(negedge clock);
    dbg_idx = 2'd1;
    #1;
    check("snoop_rd_state", dbg_state, 2'b10);
    check("wbwait_snoop_ready", snoop_ready, 0);
    check("wbwait_cpu_ready", cpu_ready, 0);
    @(negedge clock); #1;
    check("abort_one_cycle", abort_mem, 0);
    check("wb_req_held", wb_req, 1);
    check("wb_tag_held", wb_tag, 8'h5A);
    @(negedge clock);
    wb_ack = 1'b1;
    @(posedge clock); #1;
    wb_ack = 1'b0;
    @(negedge clock); #1;
    check("wb_req_dropped", wb_req, 0);
    check("snoop_ready_back", snoop_ready, 1);

    // Line 0: read miss, write hit on shared, read hit, snoop variants
    pushBus(2'b01);
    cpuReq(1'b0, 2'd0, 8'h40);
    checkDbg("rmiss_state", 2'd0, 2'b10);
    pushBus(2'b00);
    cpuReq(1'b1, 2'd0, 8'h40);
    checkDbg("whit_shared_state", 2'd0, 2'b01);
    cpuReq(1'b0, 2'd0, 8'h40);
    checkDbg("rhit_state", 2'd0, 2'b01);
    snoopReq(2'b00, 2'd0, 8'h40);
    checkDbg("inv_on_modified", 2'd0, 2'b01);
    snoopReq(2'b11, 2'd0, 8'h40);
    checkDbg("msg11_ignored", 2'd0, 2'b01);
    pushWb(2'd0, 8'h40, 1'b1);
    snoopReq(2'b10, 2'd0, 8'h40);
    ackWb();
    checkDbg("snoop_wmiss_modified", 2'd0, 2'b00);

    // Line 2 shared 0x11: mismatching invalidate ignored, matching invalidates
    pushBus(2'b01);
    cpuReq(1'b0, 2'd2, 8'h11);
    checkDbg("line2_shared", 2'd2, 2'b10);
    snoopReq(2'b00, 2'd2, 8'h12);
    checkDbg("inv_tag_mismatch", 2'd2, 2'b10);
    snoopReq(2'b00, 2'd2, 8'h11);
    checkDbg("inv_shared", 2'd2, 2'b00);
    check("inv_no_wb", wb_req, 0);

    // Same-cycle snoop and CPU request: snoop wins, CPU accepted once after
    @(negedge clock);
    snoop_valid = 1'b1; snoop_msg = 2'b01; snoop_idx = 2'd1; snoop_tag = 8'h5A;
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_idx = 2'd2; cpu_tag = 8'h77;
    pushBus(2'b10);
    #1;
    check("prio_cpu_ready", cpu_ready, 0);
    check("prio_snoop_ready", snoop_ready, 1);
    @(posedge clock); #1;
    snoop_valid = 1'b0; snoop_msg = 2'b11;
    #1;
    check("prio_cpu_ready_after", cpu_ready, 1);
    @(posedge clock); #1;
    cpu_valid = 1'b0;
    checkDbg("prio_cpu_done", 2'd2, 2'b01);
    checkDbg("prio_snoop_line", 2'd1, 2'b10);

    // Line 3: dirty eviction writes back old tag without abort
    pushBus(2'b10);
    cpuReq(1'b1, 2'd3, 8'h20);
    pushBus(2'b01);
    pushWb(2'd3, 8'h20, 1'b0);
    cpuReq(1'b0, 2'd3, 8'h30);
    checkDbg("evict_state", 2'd3, 2'b10);
    ackWb();
    cpuReq(1'b0, 2'd3, 8'h30);
    checkDbg("new_tag_hit", 2'd3, 2'b10);
    pushBus(2'b00);
    cpuReq(1'b1, 2'd3, 8'h30);
    pushBus(2'b01);
    pushWb(2'd3, 8'h30, 1'b0);
    cpuReq(1'b0, 2'd3, 8'h31);

    // Reset while in WB_WAIT abandons the write-back
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    check("rst_wbwait_wb_req", wb_req, 0);
    check("rst_wbwait_bus_msg", bus_msg, 2'b11);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) checkDbg("rst2_line_state", i[1:0], 2'b00);
    repeat (3) @(negedge clock);
    check("rst2_no_wb_req", wb_req, 0);
    check("scoreboard_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
